// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sharing controller.
// Holds the ALU opcode encodings, the highest legal opcode and the
// controller FSM state type.
package alu_pkg;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;
  localparam logic [4:0] OP_NOR = 5'd6;

  // Opcodes 1..OP_MAX reach the ALU; 0 and anything above are rejected.
  localparam int unsigned OP_MAX = 6;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
// Ports:
//   req_i  - request per input
//   last_i - index of the input granted most recently
//   en_i   - arbitration enable; grant is zero when low
//   gnt_o  - one-hot grant (or zero)
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (&req_i) begin
        // Tie: the input not granted last wins.
        gnt_o = last_i ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one external ALU between two command ports.
// Round-robin arbitration in IDLE, one EXEC cycle driving the ALU, then the
// captured result is held on the response channel until the owner accepts it.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   req_valid/req_ready        - per-port command handshake
//   req_op/req_a/req_b         - per-port packed opcode and operands
//   resp_valid/resp_ready      - per-port response handshake
//   resp_data/resp_err         - shared result and illegal-opcode flag
//   alu_a/alu_b/alu_op/alu_out - connection to the external ALU
// Optional feature macro ALU_SHARE_FLAGS_EN adds resp_zero/resp_neg.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter int unsigned OPW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*OPW-1:0] req_op,
  input  logic [2*W-1:0]   req_a,
  input  logic [2*W-1:0]   req_b,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [W-1:0]     resp_data,
  output logic             resp_err,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [W-1:0]     alu_out
`ifdef ALU_SHARE_FLAGS_EN
  ,
  output logic             resp_zero,
  output logic             resp_neg
`endif
);

  state_e         state_q;
  logic           owner_q;
  logic           last_q;
  logic [OPW-1:0] op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   res_q;
  logic           err_q;
  logic [1:0]     gnt;
  logic [OPW-1:0] sel_op;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           sel_legal;
`ifdef ALU_SHARE_FLAGS_EN
  logic           zero_q;
  logic           neg_q;
`endif

  // Grant is masked during reset so req_ready reads 0 while rst is high.
  rr_arb2 u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .en_i   ((state_q == StIdle) && !rst),
    .gnt_o  (gnt)
  );

  assign sel_op    = gnt[1] ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
  assign sel_a     = gnt[1] ? req_a[2*W-1:W]      : req_a[W-1:0];
  assign sel_b     = gnt[1] ? req_b[2*W-1:W]      : req_b[W-1:0];
  assign sel_legal = (sel_op != '0) && (sel_op <= OPW'(OP_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // port 1 "last" so port 0 wins the first tie
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
`ifdef ALU_SHARE_FLAGS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|gnt) begin
            owner_q <= gnt[1];
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            if (sel_legal) begin
              state_q <= StExec;
            end else begin
              // Illegal opcode: answer directly without touching the ALU.
              res_q   <= '0;
              err_q   <= 1'b1;
`ifdef ALU_SHARE_FLAGS_EN
              zero_q  <= 1'b0;
              neg_q   <= 1'b0;
`endif
              state_q <= StResp;
            end
          end
        end
        StExec: begin
          res_q   <= alu_out;
          err_q   <= 1'b0;
`ifdef ALU_SHARE_FLAGS_EN
          zero_q  <= (alu_out == '0);
          neg_q   <= alu_out[W-1];
`endif
          state_q <= StResp;
        end
        StResp: begin
          if (resp_ready[owner_q]) begin
            last_q  <= owner_q;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready  = gnt;
  assign resp_valid = (state_q == StResp) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_data  = res_q;
  assign resp_err   = err_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  // ALU sees NOP except in the single execute cycle.
  assign alu_op     = (state_q == StExec) ? op_q : '0;
`ifdef ALU_SHARE_FLAGS_EN
  assign resp_zero  = zero_q;
  assign resp_neg   = neg_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with an abstract cycle model and
// directed vectors. Build with ALU_SHARE_FLAGS_EN to cover the flag outputs.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  resp_ready = 2'b00;
  logic [9:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_op;
  logic [15:0] alu_out;
`ifdef ALU_SHARE_FLAGS_EN
  logic        resp_zero;
  logic        resp_neg;
`endif

  int checks = 0;
  int failures = 0;

  alu_share_ctrl #(
    .W   (16),
    .OPW (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_out    (alu_out)
`ifdef ALU_SHARE_FLAGS_EN
    ,
    .resp_zero  (resp_zero),
    .resp_neg   (resp_neg)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(input logic [4:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] r;
    case (op)
      5'd1:    r = a + b;
      5'd2:    r = a - b;
      5'd3:    r = a & b;
      5'd4:    r = a | b;
      5'd5:    r = a ^ b;
      5'd6:    r = ~(a | b);
      default: r = 16'h0;
    endcase
    return r;
  endfunction

  // External ALU; garbage on NOP so a capture outside EXEC shows up.
  always_comb begin
    alu_out = (alu_op == 5'd0) ? 16'hDEAD : ref_alu(alu_op, alu_a, alu_b);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT at %0t", nm, $time);
  endtask

  // ---------------- abstract model ----------------
  // Busy/idle with a countdown to the response; tie goes to whoever was
  // not served most recently.
  function automatic logic pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return ~last;
    return v[1];
  endfunction

  logic        m_busy = 1'b0;
  int          m_wait = 0;
  logic        m_owner = 1'b0;
  logic        m_last = 1'b1;
  logic        m_err = 1'b0;
  logic [4:0]  m_op = '0;
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;
  logic [15:0] m_res = '0;

  logic        w_port;
  logic [4:0]  w_op;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic        w_legal;
  assign w_port  = pick(req_valid, m_last);
  assign w_op    = w_port ? req_op[9:5] : req_op[4:0];
  assign w_a     = w_port ? req_a[31:16] : req_a[15:0];
  assign w_b     = w_port ? req_b[31:16] : req_b[15:0];
  assign w_legal = (w_op >= 5'd1) && (w_op <= 5'(OP_MAX));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_wait <= 0;
      m_last <= 1'b1;
      m_err  <= 1'b0;
      m_op   <= '0;
      m_a    <= '0;
      m_b    <= '0;
      m_res  <= '0;
    end else if (!m_busy) begin
      if (req_valid != 2'b00) begin
        m_busy  <= 1'b1;
        m_owner <= w_port;
        m_op    <= w_op;
        m_a     <= w_a;
        m_b     <= w_b;
        m_err   <= !w_legal;
        m_res   <= w_legal ? ref_alu(w_op, w_a, w_b) : 16'h0;
        m_wait  <= w_legal ? 1 : 0;
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
    end else if (resp_ready[m_owner]) begin
      m_busy <= 1'b0;
      m_last <= m_owner;
    end
  end

  logic [1:0] e_ready;
  logic [1:0] e_valid;
  logic [4:0] e_op;

  always @(negedge clk) begin
    e_ready = 2'b00;
    if (!rst && !m_busy && req_valid != 2'b00) e_ready = w_port ? 2'b10 : 2'b01;
    e_valid = (m_busy && m_wait == 0) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    e_op    = (m_busy && m_wait == 1) ? m_op : 5'd0;
    check("m_req_ready", req_ready, e_ready);
    check("m_resp_valid", resp_valid, e_valid);
    check("m_alu_op", alu_op, e_op);
    check("m_alu_a", alu_a, m_a);
    check("m_alu_b", alu_b, m_b);
    if (e_valid != 2'b00 || rst) begin
      check("m_resp_data", resp_data, m_res);
      check("m_resp_err", resp_err, m_err);
`ifdef ALU_SHARE_FLAGS_EN
      check("m_resp_zero", resp_zero, !rst && !m_err && (m_res == 16'h0));
      check("m_resp_neg", resp_neg, !rst && !m_err && m_res[15]);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [4:0] op, input logic [15:0] a,
                      input logic [15:0] b);
    req_op[p*5 +: 5]  = op;
    req_a[p*16 +: 16] = a;
    req_b[p*16 +: 16] = b;
    req_valid[p]      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        step();
        req_valid[p] = 1'b0;
        return;
      end
      step();
    end
    req_valid[p] = 1'b0;
    timeout_fail("send");
  endtask

  // Returns in the first cycle resp_valid[p] is high; lat counts cycles after accept.
  task automatic wait_resp(input int p, output int lat);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid[p]) return;
      step();
      lat++;
    end
    lat = -1;
    timeout_fail("wait_resp");
  endtask

  logic        r_port[2];
  logic [15:0] r_data[2];
  int          g_cyc[2];

  task automatic dual();
    int got;
    int ng;
    logic [1:0] acc;
    req_op    = {OP_AND, OP_SUB};
    req_a     = {16'hF0F0, 16'h0005};
    req_b     = {16'h0FF0, 16'h0007};
    req_valid = 2'b11;
    got = 0;
    ng  = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(negedge clk);
      acc = req_ready;
      if (acc != 2'b00 && ng < 2) begin
        g_cyc[ng] = c;
        ng++;
      end
      if (resp_valid != 2'b00) begin
        r_port[got] = resp_valid[1];
        r_data[got] = resp_data;
        got++;
      end
      step();
      req_valid = req_valid & ~acc;
    end
    req_valid = 2'b00;
    if (got < 2) timeout_fail("dual");
  endtask

  logic [4:0]  t_op[6]  = '{OP_SUB, OP_XOR, OP_ADD, OP_NOP, 5'd7, 5'd31};
  logic [15:0] t_a[6]   = '{16'h0000, 16'hAAAA, 16'hFFFF, 16'h1234, 16'h1111, 16'h2222};
  logic [15:0] t_b[6]   = '{16'h0001, 16'h5555, 16'h0002, 16'h4321, 16'h2222, 16'h3333};
  logic [15:0] t_exp[6] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
  logic        t_err[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int lat;
    // Reset values.
    step();
    req_valid = 2'b01;
    @(negedge clk);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_resp_data", resp_data, 16'h0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_alu_op", alu_op, 5'd0);
    check("rst_alu_a", alu_a, 16'h0);
    req_valid = 2'b00;
    step();
    rst = 1'b0;
    resp_ready = 2'b11;
    step();

    // ADD wrap into the sign bit.
    send(0, OP_ADD, 16'h7FFF, 16'h0001);
    wait_resp(0, lat);
    check("add_lat", lat, 2);
    check("add_data", resp_data, 16'h8000);
    check("add_err", resp_err, 1'b0);
    step();

    // Dual request from reset: p0 first, then p1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    dual();
    check("dual1_first_port", r_port[0], 1'b0);
    check("dual1_first_data", r_data[0], 16'hFFFE);
    check("dual1_second_port", r_port[1], 1'b1);
    check("dual1_second_data", r_data[1], 16'h00F0);
    check("dual1_loser_wait", g_cyc[1] - g_cyc[0], 3);

    // p0 alone, then a tie must go to p1.
    send(0, OP_OR, 16'h1200, 16'h0034);
    wait_resp(0, lat);
    check("or_data", resp_data, 16'h1234);
    step();
    dual();
    check("dual2_first_port", r_port[0], 1'b1);
    check("dual2_first_data", r_data[0], 16'h00F0);
    check("dual2_second_port", r_port[1], 1'b0);
    check("dual2_second_data", r_data[1], 16'hFFFE);

    // Illegal opcode on p1.
    send(1, 5'h09, 16'h1111, 16'h2222);
    wait_resp(1, lat);
    check("ill_lat", lat, 1);
    check("ill_data", resp_data, 16'h0);
    check("ill_err", resp_err, 1'b1);
    check("ill_alu_op", alu_op, 5'd0);
    step();

    // Back-pressure: result held, p1 waits, non-owner ready ignored.
    resp_ready = 2'b00;
    send(0, OP_NOR, 16'h0000, 16'h0000);
    req_op[9:5]   = OP_ADD;
    req_a[31:16]  = 16'h0003;
    req_b[31:16]  = 16'h0004;
    req_valid[1]  = 1'b1;
    wait_resp(0, lat);
    check("nor_lat", lat, 2);
    resp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_valid", resp_valid, 2'b01);
      check("hold_data", resp_data, 16'hFFFF);
      check("hold_req_ready", req_ready, 2'b00);
      step();
    end
    resp_ready = 2'b01;
    @(negedge clk);
    check("release_valid", resp_valid, 2'b01);
    step();
    @(negedge clk);
    check("p1_grant_after_release", req_ready, 2'b10);
    step();
    req_valid[1] = 1'b0;
    resp_ready = 2'b11;
    wait_resp(1, lat);
    check("p1_after_hold_lat", lat, 2);
    check("p1_after_hold_data", resp_data, 16'h0007);
    step();

    // Reset during EXEC drops the command.
    send(0, OP_ADD, 16'h00AA, 16'h0055);
    rst = 1'b1;
    @(negedge clk);
    check("exec_rst_resp_valid", resp_valid, 2'b00);
    check("exec_rst_alu_op", alu_op, 5'd0);
    check("exec_rst_alu_a", alu_a, 16'h0);
    check("exec_rst_alu_b", alu_b, 16'h0);
    check("exec_rst_data", resp_data, 16'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_resp_after_rst", resp_valid, 2'b00);
      step();
    end
    send(0, OP_ADD, 16'h0001, 16'h0002);
    wait_resp(0, lat);
    check("post_rst_lat", lat, 2);
    check("post_rst_data", resp_data, 16'h0003);
    step();

    // Mixed table, alternating ports.
    for (int i = 0; i < 6; i++) begin
      send(i % 2, t_op[i], t_a[i], t_b[i]);
      wait_resp(i % 2, lat);
      check("tbl_lat", lat, t_err[i] ? 1 : 2);
      check("tbl_data", resp_data, t_exp[i]);
      check("tbl_err", resp_err, t_err[i]);
      step();
    end

`ifdef ALU_SHARE_FLAGS_EN
    send(0, OP_XOR, 16'h1234, 16'h1234);
    wait_resp(0, lat);
    check("flag_xor_zero", resp_zero, 1'b1);
    check("flag_xor_neg", resp_neg, 1'b0);
    step();
    send(1, OP_SUB, 16'h0000, 16'h0001);
    wait_resp(1, lat);
    check("flag_sub_zero", resp_zero, 1'b0);
    check("flag_sub_neg", resp_neg, 1'b1);
    step();
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
